// File: rtl/lcd_pkg.sv
// Shared widths, RGB565 packing, pattern-mode encoding and bar colour table
// for the LCD timing/pattern path.
package lcd_pkg;

   localparam int R_W      = 5;
   localparam int G_W      = 6;
   localparam int B_W      = 5;
   localparam int RGB_W    = R_W + G_W + B_W;
   localparam int NUM_BARS = 8;

   typedef logic [RGB_W-1:0] rgb_t;

   typedef enum logic [1:0] {
      BARS  = 2'd0,
      GRID  = 2'd1,
      GRAD  = 2'd2,
      SOLID = 2'd3
   } mode_e;

   localparam rgb_t WHITE = 16'hFFFF;
   localparam rgb_t BLACK = 16'h0000;

   // Left-to-right colour bars: white, yellow, cyan, green, magenta, red, blue, black.
   localparam rgb_t BAR_TABLE [NUM_BARS] = '{
      16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
      16'hF81F, 16'hF800, 16'h001F, 16'h0000
   };

   // Red occupies the MSBs, blue the LSBs.
   function automatic rgb_t pack_rgb(input logic [R_W-1:0] r,
                                     input logic [G_W-1:0] g,
                                     input logic [B_W-1:0] b);
      return {r, g, b};
   endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Signal bundle between lcd_timing_gen (master), its pixel source and the panel.
// PixReq is a request without back-pressure: the source returns PixRGB in the same cycle.
interface lcd_timing_gen_if
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = 480,
   parameter int V_ACTIVE = 272
);

   localparam int X_W = $clog2(H_ACTIVE);
   localparam int Y_W = $clog2(V_ACTIVE);

   logic [1:0]     Mode;
   rgb_t           SolidRGB;
   rgb_t           PixRGB;
   logic           PixReq;
   logic [X_W-1:0] PixX;
   logic [Y_W-1:0] PixY;
   logic           FrameStart;
   logic           LCD_DE;
   logic           LCD_HSYNC;
   logic           LCD_VSYNC;
   logic [R_W-1:0] LCD_R;
   logic [G_W-1:0] LCD_G;
   logic [B_W-1:0] LCD_B;

   modport master (
      input  Mode, SolidRGB, PixRGB,
      output PixReq, PixX, PixY, FrameStart,
      output LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B
   );

   modport slave (
      output Mode, SolidRGB, PixRGB,
      input  PixReq, PixX, PixY, FrameStart,
      input  LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B
   );

endinterface

// File: rtl/lcd_pattern_gen.sv
// Combinational test-pattern colour for the current stage-1 pixel.
// Instantiated by lcd_timing_gen only when LCD_TIMING_PATTERN_EN is defined.
module lcd_pattern_gen
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = 480,
   parameter int V_ACTIVE = 272,
   parameter int X_W      = $clog2(H_ACTIVE),
   parameter int Y_W      = $clog2(V_ACTIVE)
) (
   input  mode_e          mode,
   input  logic [X_W-1:0] pix_x,
   input  logic [Y_W-1:0] pix_y,
   input  logic [2:0]     bar_idx,
   input  rgb_t           solid,
   output rgb_t           rgb
);

   logic [7:0] x8;
   logic       on_grid;

   always_comb begin
      x8      = 8'(pix_x);
      on_grid = (pix_x[3:0] == 4'd0) || (pix_y[3:0] == 4'd0) ||
                (pix_x == X_W'(H_ACTIVE - 1)) || (pix_y == Y_W'(V_ACTIVE - 1));
      rgb     = BLACK;
      case (mode)
         BARS:    rgb = BAR_TABLE[bar_idx];
         GRID:    rgb = on_grid ? WHITE : BLACK;
         // Gradient deliberately wraps every 256 columns.
         GRAD:    rgb = pack_rgb(x8[7:3], x8[7:2], x8[7:3]);
         SOLID:   rgb = solid;
         default: rgb = BLACK;
      endcase
   end

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised RGB565 LCD timing generator with pixel-request interface.
// Define LCD_TIMING_PATTERN_EN to embed the test-pattern engine instead of using PixRGB.
module lcd_timing_gen
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = 480,
   parameter int H_FP     = 2,
   parameter int H_SYNC   = 41,
   parameter int H_BP     = 2,
   parameter int V_ACTIVE = 272,
   parameter int V_FP     = 2,
   parameter int V_SYNC   = 10,
   parameter int V_BP     = 2,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input logic              PixelClk,
   input logic              RST,
   lcd_timing_gen_if.master bus
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int H_OFF   = H_SYNC + H_BP;
   localparam int V_OFF   = V_SYNC + V_BP;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);
   localparam int X_W     = $clog2(H_ACTIVE);
   localparam int Y_W     = $clog2(V_ACTIVE);

   logic [H_W-1:0] h;
   logic [V_W-1:0] v;
   logic           h_act;
   logic           v_act;
   logic           active;
   logic           frame_origin;
   logic [X_W-1:0] x_next;
   logic [Y_W-1:0] y_next;

   logic           s1_de;
   logic           s1_hs;
   logic           s1_vs;
   logic           s1_fs;
   logic [X_W-1:0] s1_x;
   logic [Y_W-1:0] s1_y;

   logic           lcd_de;
   logic           lcd_hs;
   logic           lcd_vs;
   logic           frame_start;
   rgb_t           rgb_q;
   rgb_t           pix_rgb;

   always_ff @(posedge PixelClk) begin
      if (RST) begin
         h <= '0;
         v <= '0;
      end else if (h == H_W'(H_TOTAL - 1)) begin
         h <= '0;
         v <= (v == V_W'(V_TOTAL - 1)) ? '0 : v + 1'b1;
      end else begin
         h <= h + 1'b1;
      end
   end

   always_comb begin
      h_act        = (h >= H_W'(H_OFF)) && (h < H_W'(H_OFF + H_ACTIVE));
      v_act        = (v >= V_W'(V_OFF)) && (v < V_W'(V_OFF + V_ACTIVE));
      active       = h_act && v_act;
      frame_origin = (h == '0) && (v == '0);
      x_next       = X_W'(h - H_W'(H_OFF));
      y_next       = Y_W'(v - V_W'(V_OFF));
   end

   // Stage 1: pixel request and coordinates, one cycle ahead of the panel.
   always_ff @(posedge PixelClk) begin
      if (RST) begin
         s1_de <= 1'b0;
         s1_hs <= 1'b0;
         s1_vs <= 1'b0;
         s1_fs <= 1'b0;
         s1_x  <= '0;
         s1_y  <= '0;
      end else begin
         s1_de <= active;
         s1_hs <= (h < H_W'(H_SYNC));
         s1_vs <= (v < V_W'(V_SYNC));
         s1_fs <= frame_origin;
         s1_x  <= active ? x_next : '0;
         s1_y  <= active ? y_next : '0;
      end
   end

`ifdef LCD_TIMING_PATTERN_EN
   localparam int BAR_W  = H_ACTIVE / 8;
   localparam int BP_W   = $clog2(BAR_W);

   mode_e           mode_q;
   logic [BP_W-1:0] bar_px;
   logic [2:0]      bar_idx;
   rgb_t            pat_rgb;
   logic            unused_pix;

   // Mode only changes at the frame origin so a frame is never mixed.
   always_ff @(posedge PixelClk) begin
      if (RST) begin
         mode_q <= BARS;
      end else if (frame_origin) begin
         mode_q <= mode_e'(bus.Mode);
      end
   end

   // Bar counter runs alongside s1_x; any columns beyond 8*BAR_W stay on bar 7.
   always_ff @(posedge PixelClk) begin
      if (RST || !active || (h == H_W'(H_OFF))) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (bar_px == BP_W'(BAR_W - 1)) begin
         bar_px  <= '0;
         bar_idx <= (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
      end else begin
         bar_px  <= bar_px + 1'b1;
      end
   end

   lcd_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .X_W      (X_W),
      .Y_W      (Y_W)
   ) u_pattern (
      .mode    (mode_q),
      .pix_x   (s1_x),
      .pix_y   (s1_y),
      .bar_idx (bar_idx),
      .solid   (bus.SolidRGB),
      .rgb     (pat_rgb)
   );

   assign pix_rgb    = pat_rgb;
   assign unused_pix = ^bus.PixRGB;
`else
   logic unused_cfg;

   assign pix_rgb    = bus.PixRGB;
   assign unused_cfg = ^{bus.Mode, bus.SolidRGB};
`endif

   // Stage 2: panel outputs with polarity applied; colour blanked outside DE.
   always_ff @(posedge PixelClk) begin
      if (RST) begin
         lcd_de      <= 1'b0;
         lcd_hs      <= ~HS_POL;
         lcd_vs      <= ~VS_POL;
         frame_start <= 1'b0;
         rgb_q       <= '0;
      end else begin
         lcd_de      <= s1_de;
         lcd_hs      <= s1_hs ? HS_POL : ~HS_POL;
         lcd_vs      <= s1_vs ? VS_POL : ~VS_POL;
         frame_start <= s1_fs;
         rgb_q       <= s1_de ? pix_rgb : '0;
      end
   end

   assign bus.PixReq     = s1_de;
   assign bus.PixX       = s1_x;
   assign bus.PixY       = s1_y;
   assign bus.FrameStart = frame_start;
   assign bus.LCD_DE     = lcd_de;
   assign bus.LCD_HSYNC  = lcd_hs;
   assign bus.LCD_VSYNC  = lcd_vs;
   assign bus.LCD_R      = rgb_q[RGB_W-1 -: R_W];
   assign bus.LCD_G      = rgb_q[B_W +: G_W];
   assign bus.LCD_B      = rgb_q[0 +: B_W];

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen on a reduced 41x21 raster.
// Covers the pattern engine when LCD_TIMING_PATTERN_EN is defined, PixRGB pass-through otherwise.
module tb_lcd_timing_gen;

   localparam int H_ACTIVE = 32;
   localparam int H_FP     = 2;
   localparam int H_SYNC   = 4;
   localparam int H_BP     = 3;
   localparam int V_ACTIVE = 16;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 2;
   localparam bit HS_POL   = 1'b0;
   localparam bit VS_POL   = 1'b0;

   localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int FRAME    = H_TOTAL * V_TOTAL;
   localparam int H_OFF    = H_SYNC + H_BP;
   localparam int V_OFF    = V_SYNC + V_BP;
   localparam int XW       = $clog2(H_ACTIVE);
   localparam int YW       = $clog2(V_ACTIVE);
   localparam int BAR_W    = H_ACTIVE / 8;
   localparam int S1_W     = 1 + XW + YW;
   localparam int LCD_W    = 20;
   localparam logic [LCD_W-1:0] RST_LCD = {1'b0, !HS_POL, !VS_POL, 1'b0, 16'h0000};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lcd_timing_gen_if #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) bus ();

   lcd_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .HS_POL   (HS_POL),   .VS_POL (VS_POL)
   ) dut (
      .PixelClk (clk),
      .RST      (rst),
      .bus      (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [S1_W-1:0]  exp_s1_q[$];
   logic [LCD_W-1:0] exp_lcd_q[$];

   // Reference raster model state: counter position of the current cycle.
   int         mh, mv, m_x, m_y;
   logic       m_de, m_hs, m_vs, m_fs;
   logic [1:0] m_mode;
   logic [1:0] mode_drv;
   logic [15:0] solid_drv;

   // Run-time measurements.
   int   cyc, rel, last_fs_cyc, line_cnt, de_run, hs_run;
   logic fs_seen, de_seen, line_cnt_on, prev_de;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [LCD_W-1:0] lcd_obs();
      return {bus.LCD_DE, bus.LCD_HSYNC, bus.LCD_VSYNC, bus.FrameStart,
              bus.LCD_R, bus.LCD_G, bus.LCD_B};
   endfunction

   function automatic logic [S1_W-1:0] s1_obs();
      return {bus.PixReq, bus.PixX, bus.PixY};
   endfunction

`ifdef LCD_TIMING_PATTERN_EN
   function automatic logic [15:0] pattern_model(input logic [1:0] m, input int x, input int y,
                                                 input logic [15:0] solid);
      int         b;
      logic [7:0] x8;
      case (m)
         2'd0: begin
            b = x / BAR_W;
            if (b > 7) b = 7;
            case (b)
               0:       return 16'hFFFF;
               1:       return 16'hFFE0;
               2:       return 16'h07FF;
               3:       return 16'h07E0;
               4:       return 16'hF81F;
               5:       return 16'hF800;
               6:       return 16'h001F;
               default: return 16'h0000;
            endcase
         end
         2'd1: return ((x % 16) == 0 || (y % 16) == 0 || x == H_ACTIVE - 1 || y == V_ACTIVE - 1)
                      ? 16'hFFFF : 16'h0000;
         2'd2: begin
            x8 = x[7:0];
            return {x8[7:3], x8[7:2], x8[7:3]};
         end
         default: return solid;
      endcase
   endfunction
`endif

   // Drive one cycle, push what the DUT must show after the edge, then compare.
   task automatic drive_cycle(input logic rst_v, input logic [15:0] pix_v);
      logic [15:0]      px;
      logic             act;
      logic [LCD_W-1:0] e_lcd;
      logic [S1_W-1:0]  e_s1;
      logic [LCD_W-1:0] got_lcd;
      logic [S1_W-1:0]  got_s1;
      rst          = rst_v;
      bus.Mode     = mode_drv;
      bus.SolidRGB = solid_drv;
      bus.PixRGB   = pix_v;
      if (rst_v) begin
         e_lcd  = RST_LCD;
         e_s1   = '0;
         m_de   = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_fs = 1'b0;
         m_x    = 0;    m_y  = 0;
         mh     = 0;    mv   = 0;
         m_mode = 2'd0;
      end else begin
`ifdef LCD_TIMING_PATTERN_EN
         px = pattern_model(m_mode, m_x, m_y, solid_drv);
`else
         px = pix_v;
`endif
         e_lcd = {m_de, (m_hs ? HS_POL : !HS_POL), (m_vs ? VS_POL : !VS_POL), m_fs,
                  (m_de ? px : 16'h0000)};
         act  = (mh >= H_OFF) && (mh < H_OFF + H_ACTIVE) && (mv >= V_OFF) && (mv < V_OFF + V_ACTIVE);
         m_de = act;
         m_x  = act ? mh - H_OFF : 0;
         m_y  = act ? mv - V_OFF : 0;
         m_hs = (mh < H_SYNC);
         m_vs = (mv < V_SYNC);
         m_fs = (mh == 0) && (mv == 0);
         if (mh == 0 && mv == 0) m_mode = mode_drv;
         if (mh == H_TOTAL - 1) begin
            mh = 0;
            mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
         e_s1 = {act, XW'(m_x), YW'(m_y)};
      end
      exp_s1_q.push_back(e_s1);
      exp_lcd_q.push_back(e_lcd);

      @(posedge clk);
      #1;
      cyc++;
      got_s1  = s1_obs();
      got_lcd = lcd_obs();
      if (exp_s1_q.size() == 0 || exp_lcd_q.size() == 0) begin
         check("queue_empty", 32'd1, 32'd0);
      end else begin
         check("s1", 32'(got_s1), 32'(exp_s1_q.pop_front()));
         check("lcd", 32'(got_lcd), 32'(exp_lcd_q.pop_front()));
      end

      if (rst_v) begin
         rel = 0; fs_seen = 1'b0; de_seen = 1'b0; line_cnt_on = 1'b0;
         last_fs_cyc = -1; de_run = 0; hs_run = 0; prev_de = 1'b0; line_cnt = 0;
      end else begin
         rel++;
         if (bus.FrameStart) begin
            if (!fs_seen) check("fs_first", rel, 2);
            fs_seen = 1'b1;
            if (last_fs_cyc >= 0) check("fs_period", cyc - last_fs_cyc, FRAME);
            if (line_cnt_on) check("de_lines", line_cnt, V_ACTIVE);
            last_fs_cyc = cyc;
            line_cnt    = 0;
            line_cnt_on = 1'b1;
         end
         if (bus.LCD_DE && !prev_de) begin
            if (!de_seen) check("de_first", rel, 2 + V_OFF * H_TOTAL + H_OFF);
            de_seen = 1'b1;
            line_cnt++;
         end
         if (bus.LCD_DE) de_run++;
         else if (prev_de) begin
            check("de_width", de_run, H_ACTIVE);
            de_run = 0;
         end
         prev_de = bus.LCD_DE;
         if (bus.LCD_HSYNC == HS_POL) hs_run++;
         else if (hs_run > 0) begin
            check("hs_width", hs_run, H_SYNC);
            hs_run = 0;
         end
      end
   endtask

   initial begin
      cyc = 0; rel = 0; last_fs_cyc = -1; line_cnt = 0; de_run = 0; hs_run = 0;
      fs_seen = 1'b0; de_seen = 1'b0; line_cnt_on = 1'b0; prev_de = 1'b0;
      mh = 0; mv = 0; m_x = 0; m_y = 0;
      m_de = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_fs = 1'b0; m_mode = 2'd0;
      mode_drv  = 2'd0;
      solid_drv = 16'hF800;
      rst = 1'b1;
      bus.Mode = 2'd0; bus.SolidRGB = 16'hF800; bus.PixRGB = 16'h0000;

      repeat (3) drive_cycle(1'b1, 16'($urandom_range(0, 16'hFFFF)));
      check("rst_lcd", 32'(lcd_obs()), 32'(RST_LCD));
      check("rst_s1", 32'(s1_obs()), 32'd0);

      // Frame 1: bars; mode switched to solid halfway, pixel source held constant.
      for (int i = 0; i < FRAME / 2; i++) drive_cycle(1'b0, 16'($urandom_range(0, 16'hFFFF)));
      mode_drv = 2'd3;
      for (int i = 0; i < FRAME; i++) drive_cycle(1'b0, 16'h1234);
      mode_drv = 2'd1;
      for (int i = 0; i < FRAME; i++) drive_cycle(1'b0, 16'($urandom_range(0, 16'hFFFF)));
      mode_drv = 2'd2;
      for (int i = 0; i < FRAME; i++) drive_cycle(1'b0, 16'($urandom_range(0, 16'hFFFF)));

      // Move to the middle of an active line, then pulse reset for one cycle.
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (mv == V_OFF + 3 && mh == H_OFF + H_ACTIVE / 2) break;
         drive_cycle(1'b0, 16'($urandom_range(0, 16'hFFFF)));
      end
      check("de_before_rst", 32'(bus.LCD_DE), 32'd1);
      drive_cycle(1'b1, 16'($urandom_range(0, 16'hFFFF)));
      check("rst_mid_lcd", 32'(lcd_obs()), 32'(RST_LCD));
      check("rst_mid_s1", 32'(s1_obs()), 32'd0);
      for (int i = 0; i < FRAME + 60; i++) drive_cycle(1'b0, 16'($urandom_range(0, 16'hFFFF)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
